// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard controller: RAW stall/forwarding and jump flush
//
// Purpose: tracks the destination registers of the EX and WB stages, resolves
// read-after-write hazards for the ID-stage instruction (forwarding selects or
// a stall) and squashes instructions behind an accepted jump for FLUSH_CYCLES
// cycles.
//
// Optional feature: macro HAZARD_FWD_EN enables operand forwarding. When it is
// not defined, forwarding selects stay 00 and RAW hazards stall instead.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-high reset
//   id_valid     in   instruction present in ID
//   id_opcode    in   [1:0] 0x = ALU op (reads ra/rb, writes ra), 1x = jump
//   id_ra, id_rb in   source register addresses (id_ra is also destination)
//   ext_stall    in   external freeze request
//   pc_en        out  PC update enable
//   ifid_en      out  IF/ID load enable
//   flushed      out  ID instruction squashed
//   fwd_a, fwd_b out  operand select: 00 regfile, 01 EX result, 10 WB result
//   hazard_stall out  internal RAW stall active

module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int REG_ADDR_W   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [1:0]            id_opcode,
  input  logic [REG_ADDR_W-1:0] id_ra,
  input  logic [REG_ADDR_W-1:0] id_rb,
  input  logic                  ext_stall,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  flushed,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  hazard_stall
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  ex_wr_q, ex_wr_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic                  wb_wr_q, wb_wr_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;

  logic is_alu;
  logic advance;
  logic ex_match_a, ex_match_b, wb_match_a, wb_match_b;
  logic unused_opcode_lsb;

  // The ALU op flavour does not matter for hazard tracking.
  assign unused_opcode_lsb = id_opcode[0];

  assign flushed = (state_q == S_FLUSH);

  // Only a live, unsquashed ALU op reads registers; jumps and squashed slots
  // never create hazards or forwarding.
  assign is_alu = id_valid & ~id_opcode[1] & ~flushed;

  assign ex_match_a = ex_wr_q & (ex_rd_q == id_ra);
  assign ex_match_b = ex_wr_q & (ex_rd_q == id_rb);
  assign wb_match_a = wb_wr_q & (wb_rd_q == id_ra);
  assign wb_match_b = wb_wr_q & (wb_rd_q == id_rb);

`ifdef HAZARD_FWD_EN
  // EX holds the youngest value, so it wins over WB.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (is_alu) begin
      if (ex_match_a)      fwd_a = 2'b01;
      else if (wb_match_a) fwd_a = 2'b10;
      if (ex_match_b)      fwd_b = 2'b01;
      else if (wb_match_b) fwd_b = 2'b10;
    end
  end
  assign hazard_stall = 1'b0;
`else
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
  // Stall while the producer sits in EX or WB; the regfile is valid once it leaves.
  assign hazard_stall = is_alu & (ex_match_a | ex_match_b | wb_match_a | wb_match_b);
`endif

  assign advance = ~ext_stall & ~hazard_stall;
  assign pc_en   = advance;
  assign ifid_en = advance;

  always_comb begin
    ex_wr_d = ex_wr_q;
    ex_rd_d = ex_rd_q;
    wb_wr_d = wb_wr_q;
    wb_rd_d = wb_rd_q;
    if (!ext_stall) begin
      wb_wr_d = ex_wr_q;
      wb_rd_d = ex_rd_q;
      if (hazard_stall) begin
        ex_wr_d = 1'b0;             // bubble; ex_rd is don't-care and held
      end else begin
        ex_wr_d = is_alu;
        ex_rd_d = id_ra;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (advance && id_valid && id_opcode[1]) begin
          state_d = S_FLUSH;
          cnt_d   = FLUSH_LOAD;
        end
      end
      S_FLUSH: begin
        // Jumps seen here are squashed, so they neither re-trigger nor reload.
        if (!ext_stall) begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      ex_wr_q <= 1'b0;
      ex_rd_q <= '0;
      wb_wr_q <= 1'b0;
      wb_rd_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_wr_q <= ex_wr_d;
      ex_rd_q <= ex_rd_d;
      wb_wr_q <= wb_wr_d;
      wb_rd_q <= wb_rd_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl

module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [1:0] id_opcode;
  logic [2:0] id_ra, id_rb;
  logic       ext_stall;

  logic       pc_en1, ifid_en1, flushed1, hz1;
  logic [1:0] fwd_a1, fwd_b1;
  logic       pc_en2, ifid_en2, flushed2, hz2;
  logic [1:0] fwd_a2, fwd_b2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .REG_ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_ra(id_ra), .id_rb(id_rb), .ext_stall(ext_stall),
    .pc_en(pc_en1), .ifid_en(ifid_en1), .flushed(flushed1),
    .fwd_a(fwd_a1), .fwd_b(fwd_b1), .hazard_stall(hz1)
  );

  pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .REG_ADDR_W(3)) dut2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_ra(id_ra), .id_rb(id_rb), .ext_stall(ext_stall),
    .pc_en(pc_en2), .ifid_en(ifid_en2), .flushed(flushed2),
    .fwd_a(fwd_a2), .fwd_b(fwd_b2), .hazard_stall(hz2)
  );

  typedef struct {
    logic       rs, v;
    logic [1:0] op;
    logic [2:0] ra, rb;
    logic       es;
    logic       pc, fl;
    logic [1:0] fa, fb;
    logic       hz;
  } vec_t;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rs, input logic v, input logic [1:0] op,
                       input logic [2:0] ra, input logic [2:0] rb, input logic es);
    reset = rs; id_valid = v; id_opcode = op; id_ra = ra; id_rb = rb; ext_stall = es;
  endtask

  // Move to the next cycle: inputs change 1 time unit after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

`ifndef HAZARD_FWD_EN
  vec_t tbl[32];

  task automatic run_table();
    // rs v  op ra rb es | pc fl fa fb hz
    tbl[0]  = '{1,0,2'd0,3'd0,3'd0,0, 1,0,2'd0,2'd0,0}; // reset state
    tbl[1]  = '{0,1,2'd0,3'd1,3'd2,0, 1,0,2'd0,2'd0,0}; // ADD r1,r2
    tbl[2]  = '{0,1,2'd0,3'd4,3'd1,0, 0,0,2'd0,2'd0,1}; // ADD r4,r1: r1 in EX
    tbl[3]  = '{0,1,2'd0,3'd4,3'd1,0, 0,0,2'd0,2'd0,1}; // r1 in WB
    tbl[4]  = '{0,1,2'd0,3'd4,3'd1,0, 1,0,2'd0,2'd0,0}; // producer gone
    tbl[5]  = '{0,1,2'd2,3'd0,3'd0,0, 1,0,2'd0,2'd0,0}; // jump accepted
    tbl[6]  = '{0,1,2'd0,3'd4,3'd4,0, 1,1,2'd0,2'd0,0}; // squashed, no stall on r4
    tbl[7]  = '{0,1,2'd0,3'd4,3'd4,0, 1,0,2'd0,2'd0,0}; // squashed op wrote nothing
    tbl[8]  = '{0,1,2'd0,3'd5,3'd4,1, 0,0,2'd0,2'd0,1}; // RAW + ext_stall
    tbl[9]  = '{0,1,2'd0,3'd5,3'd4,1, 0,0,2'd0,2'd0,1}; // frozen: r4 still in EX
    tbl[10] = '{0,1,2'd0,3'd5,3'd4,0, 0,0,2'd0,2'd0,1}; // EX match
    tbl[11] = '{0,1,2'd0,3'd5,3'd4,0, 0,0,2'd0,2'd0,1}; // WB match
    tbl[12] = '{0,1,2'd0,3'd5,3'd4,0, 1,0,2'd0,2'd0,0}; // consumer advances
    tbl[13] = '{0,1,2'd2,3'd0,3'd0,0, 1,0,2'd0,2'd0,0}; // jump, r5 in EX ignored
    tbl[14] = '{0,0,2'd0,3'd0,3'd0,1, 0,1,2'd0,2'd0,0}; // ext_stall in FLUSH
    tbl[15] = '{0,0,2'd0,3'd0,3'd0,1, 0,1,2'd0,2'd0,0};
    tbl[16] = '{0,0,2'd0,3'd0,3'd0,1, 0,1,2'd0,2'd0,0};
    tbl[17] = '{0,0,2'd0,3'd0,3'd0,0, 1,1,2'd0,2'd0,0}; // released, flush completes
    tbl[18] = '{0,0,2'd0,3'd0,3'd0,0, 1,0,2'd0,2'd0,0};
    tbl[19] = '{0,1,2'd3,3'd0,3'd0,1, 0,0,2'd0,2'd0,0}; // jump during ext_stall
    tbl[20] = '{0,1,2'd3,3'd0,3'd0,0, 1,0,2'd0,2'd0,0}; // accepted now
    tbl[21] = '{0,0,2'd0,3'd0,3'd0,0, 1,1,2'd0,2'd0,0};
    tbl[22] = '{0,0,2'd0,3'd0,3'd0,0, 1,0,2'd0,2'd0,0};
    tbl[23] = '{0,1,2'd0,3'd6,3'd7,0, 1,0,2'd0,2'd0,0}; // ADD r6,r7
    tbl[24] = '{0,1,2'd0,3'd1,3'd6,0, 0,0,2'd0,2'd0,1}; // RAW on r6
    tbl[25] = '{1,1,2'd0,3'd1,3'd6,0, 1,0,2'd0,2'd0,0}; // reset mid-stall
    tbl[26] = '{0,1,2'd0,3'd1,3'd6,0, 1,0,2'd0,2'd0,0}; // tracking cleared; ADD r1,r6
    tbl[27] = '{0,0,2'd0,3'd1,3'd1,0, 1,0,2'd0,2'd0,0}; // invalid never stalls
    tbl[28] = '{0,1,2'd0,3'd1,3'd0,0, 0,0,2'd0,2'd0,1}; // r1 in WB
    tbl[29] = '{0,1,2'd2,3'd0,3'd0,0, 1,0,2'd0,2'd0,0}; // jump accepted
    tbl[30] = '{1,0,2'd0,3'd0,3'd0,0, 1,0,2'd0,2'd0,0}; // reset mid-flush
    tbl[31] = '{0,0,2'd0,3'd0,3'd0,0, 1,0,2'd0,2'd0,0}; // no residual flush
    for (int i = 0; i < 32; i++) begin
      drive(tbl[i].rs, tbl[i].v, tbl[i].op, tbl[i].ra, tbl[i].rb, tbl[i].es);
      @(negedge clk);
      chk($sformatf("v%0d_pc_en", i),   {3'b0, pc_en1},   {3'b0, tbl[i].pc});
      chk($sformatf("v%0d_ifid_en", i), {3'b0, ifid_en1}, {3'b0, tbl[i].pc});
      chk($sformatf("v%0d_flushed", i), {3'b0, flushed1}, {3'b0, tbl[i].fl});
      chk($sformatf("v%0d_hazard", i),  {3'b0, hz1},      {3'b0, tbl[i].hz});
      chk($sformatf("v%0d_fwd", i),     {fwd_a1, fwd_b1}, {tbl[i].fa, tbl[i].fb});
      next_cycle();
    end
  endtask
`else
  task automatic run_fwd();
    drive(1, 0, 2'd0, 3'd0, 3'd0, 0);
    next_cycle();
    drive(0, 1, 2'd0, 3'd1, 3'd2, 0);               // ADD r1,r2
    @(negedge clk);
    chk("fwd_c1", {fwd_a1, fwd_b1}, 4'b0000);
    next_cycle();
    drive(0, 1, 2'd0, 3'd3, 3'd1, 0);               // ADD r3,r1
    @(negedge clk);
    chk("fwd_c2", {fwd_a1, fwd_b1}, 4'b0001);
    chk("fwd_c2_hz", {3'b0, hz1}, 4'd0);
    chk("fwd_c2_pc", {3'b0, pc_en1}, 4'd1);
    next_cycle();
    drive(0, 1, 2'd0, 3'd1, 3'd5, 0);               // ADD r1,r5
    @(negedge clk);
    chk("fwd_c3", {fwd_a1, fwd_b1}, 4'b1000);
    next_cycle();
    drive(0, 1, 2'd0, 3'd3, 3'd1, 0);               // r1 in EX, r3 in WB
    @(negedge clk);
    chk("fwd_c4", {fwd_a1, fwd_b1}, 4'b1001);
    next_cycle();
    drive(0, 1, 2'd2, 3'd3, 3'd3, 0);               // jump: no forwarding
    @(negedge clk);
    chk("fwd_jump", {fwd_a1, fwd_b1}, 4'b0000);
    next_cycle();
    drive(0, 0, 2'd0, 3'd3, 3'd3, 0);               // squashed slot
    @(negedge clk);
    chk("fwd_flushed", {fwd_a1, fwd_b1}, 4'b0000);
    chk("fwd_flushed_fl", {3'b0, flushed1}, 4'd1);
    next_cycle();
  endtask
`endif

  task automatic run_flush2();
    // Jump with FLUSH_CYCLES=2; jumps during the flush must not extend it.
    drive(1, 0, 2'd0, 3'd0, 3'd0, 0);
    next_cycle();
    drive(0, 1, 2'd2, 3'd0, 3'd0, 0);
    @(negedge clk);
    chk("f2_pre", {3'b0, flushed2}, 4'd0);
    next_cycle();
    @(negedge clk);
    chk("f2_c1", {3'b0, flushed2}, 4'd1);
    next_cycle();
    @(negedge clk);
    chk("f2_c2", {3'b0, flushed2}, 4'd1);
    next_cycle();
    drive(0, 0, 2'd0, 3'd0, 3'd0, 0);
    @(negedge clk);
    chk("f2_end", {3'b0, flushed2}, 4'd0);
    chk("f2_end_pc", {3'b0, pc_en2}, 4'd1);
    next_cycle();

    // Reset pulse in the middle of a 2-cycle flush.
    drive(0, 1, 2'd2, 3'd0, 3'd0, 0);
    next_cycle();
    drive(0, 0, 2'd0, 3'd0, 3'd0, 0);
    @(negedge clk);
    chk("f2r_in_flush", {3'b0, flushed2}, 4'd1);
    #1 reset = 1'b1;
    #1;
    chk("f2r_async", {3'b0, flushed2}, 4'd0);
    chk("f2r_async_pc", {3'b0, pc_en2}, 4'd1);
    next_cycle();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("f2r_after%0d_fl", k), {3'b0, flushed2}, 4'd0);
      chk($sformatf("f2r_after%0d_pc", k), {3'b0, pc_en2}, 4'd1);
      next_cycle();
    end
  endtask

  initial begin
    drive(1, 0, 2'd0, 3'd0, 3'd0, 0);
    #1;
`ifndef HAZARD_FWD_EN
    run_table();
`else
    run_fwd();
`endif
    run_flush2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 1: number of cycles flushed is held after an accepted jump (legal range 1..3).
REQ-002 Parameter REG_ADDR_W, default 3: register address width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 id_valid  input  1  instruction present in the ID stage.
REQ-006 id_opcode  input  2  ID-stage opcode: 00/01 are ALU ops that read ra and rb and write ra; 1x is a jump that reads nothing and writes nothing.
REQ-007 id_ra, id_rb  input  REG_ADDR_W each  ID-stage source register addresses; id_ra is also the destination.
REQ-008 ext_stall  input  1  external freeze request, e.g. from memory.
REQ-009 pc_en  output  1  PC update enable.
REQ-010 ifid_en  output  1  IF/ID register load enable.
REQ-011 flushed  output  1  ID instruction is squashed; drives the control unit's RegWrite suppression.
REQ-012 fwd_a, fwd_b  output  2 each  operand source select: 00 = register file, 01 = EX result, 10 = WB result.
REQ-013 hazard_stall  output  1  internal RAW stall is active.

Function
REQ-014 Tracking registers ex_wr/ex_rd and wb_wr/wb_rd record the destination register of the instructions in EX and WB.
REQ-015 Advance cycle (ext_stall=0, hazard_stall=0):
  - ex_wr <= id_valid & ~id_opcode[1] & ~flushed.
  - ex_rd <= id_ra.
  - wb_* <= ex_*.
REQ-016 When ext_stall=1, all tracking and FSM state is held, and pc_en = ifid_en = 0.
REQ-017 When hazard_stall=1 and ext_stall=0:
  - pc_en = ifid_en = 0.
  - A bubble is inserted: ex_wr <= 0.
  - WB still advances: wb_* <= ex_*.
REQ-018 In all other cycles, pc_en = ifid_en = 1.
REQ-019 FSM states are IDLE and FLUSH, with a counter of width 2.
  - IDLE -> FLUSH on an accepted jump: id_valid & id_opcode[1] & ~flushed in an advance cycle. The counter loads FLUSH_CYCLES.
  - In FLUSH, the counter decrements on each non-ext_stall cycle.
  - FLUSH -> IDLE when the counter reaches 1 and the cycle is not ext_stalled.
REQ-020 flushed = 1 exactly when state = FLUSH, so flushed is a registered output: jump accepted at edge t gives flushed=1 for cycles t+1 .. t+FLUSH_CYCLES, excluding ext_stall cycles.
REQ-021 A jump that appears in ID while flushed=1 is ignored: no re-trigger and no counter reload.
REQ-022 A jump in ID during ext_stall is not accepted until the first non-stalled cycle.
REQ-023 Forwarding priority per operand: EX match (ex_wr & ex_rd == src) -> 01; else WB match -> 10; else 00. Jumps, invalid instructions and flushed instructions output 00.
REQ-024 With forwarding enabled, hazard_stall is constantly 0.

Reset
REQ-025 While reset is high:
  - state = IDLE, counter = 0.
  - ex_wr = wb_wr = 0, ex_rd = wb_rd = 0.
  - Outputs: flushed=0, pc_en=1, ifid_en=1, fwd_a=fwd_b=00, hazard_stall=0.
REQ-026 Reset asserted mid-FLUSH or mid-stall abandons that operation immediately, with no residual flush after reset release.

Configuration
REQ-027 Macro HAZARD_FWD_EN controls forwarding.
  - Defined: forwarding operates per REQ-023 and REQ-024.
  - Not defined: fwd_a = fwd_b = 00 always, and hazard_stall = id_valid & ~flushed & ~id_opcode[1] & (any EX or WB match on id_ra or id_rb). The stall holds until the producer has left WB.

Verification
REQ-028 Reset pulse during FLUSH with FLUSH_CYCLES=2 -> flushed=0 immediately; after release, pc_en=1 and no flush cycles follow.
REQ-029 ADD r1,r2 then ADD r3,r1 back-to-back, with HAZARD_FWD_EN -> in cycle 2, fwd_a=00 and fwd_b=01. Third instruction ADD r1,r5 -> fwd_a=10 (r1 in WB) and fwd_b=00.
REQ-030 Jump accepted with FLUSH_CYCLES=2 -> flushed=1 for exactly the 2 following cycles; a jump in ID during those cycles does not extend the flush.
REQ-031 ext_stall held 3 cycles during FLUSH (FLUSH_CYCLES=1) -> pc_en=ifid_en=0 for 3 cycles, flushed stays 1, then drops 1 cycle after ext_stall releases.
REQ-032 Without HAZARD_FWD_EN, ADD r1,r2 followed by ADD r4,r1 -> hazard_stall=1 for 2 cycles with ex_wr bubbles inserted, then the consumer advances with fwd_*=00.
REQ-033 ext_stall and a RAW hazard simultaneously (no HAZARD_FWD_EN) -> all tracking state frozen and WB does not advance until ext_stall=0.
